// File: rtl/mvmul_seq.sv
// mvmul_seq: sequential N x N matrix times N-vector, one column per cycle, valid/ready handshake
module mvmul_seq #(
  parameter int N   = 4,
  parameter int W   = 10,
  parameter int SAT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*N*W-1:0]   A,
  input  logic [N*W-1:0]     P,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*W-1:0]     C,
  output logic               ovf,
  output logic               busy
);
  localparam int AW = 2*W + $clog2(N);
  localparam int KW = $clog2(N);
  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
  state_t                 state_q, state_d;
  logic [N*N*W-1:0]       a_q;
  logic [N*W-1:0]         p_q;
  logic [N-1:0][AW-1:0]   acc_q, acc_d;
  logic [KW-1:0]          k_q;
  logic [N*W-1:0]         c_q, c_d;
  logic                   ovf_q, ovf_d;
  logic                   last;
  assign last = k_q == KW'(N-1);
  // State register; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  // Next state: accept in IDLE, finish after column N-1, release on out_ready
  always_comb
    state_d = (state_q == IDLE && in_valid)  ? MAC  :
              (state_q == MAC  && last)      ? DONE :
              (state_q == DONE && out_ready) ? IDLE : state_q;
  // Handshake outputs decoded straight from the state register
  always_comb begin
    in_ready  = state_q == IDLE;
    busy      = state_q != IDLE;
    out_valid = state_q == DONE;
  end
  // One column step of all rows plus the wrap/saturate view of the result
  always_comb begin
    acc_d = acc_q;
    c_d   = '0;
    ovf_d = 1'b0;
    for (int r = 0; r < N; r++) begin
      acc_d[r] = acc_q[r] + AW'(a_q[(N*N-1-r*N-int'(k_q))*W +: W]) * AW'(p_q[(N-1-int'(k_q))*W +: W]);
      c_d[(N-1-r)*W +: W] = (SAT != 0 && |acc_d[r][AW-1:W]) ? {W{1'b1}} : acc_d[r][W-1:0];
      ovf_d = ovf_d | (|acc_d[r][AW-1:W]);
    end
  end
  // Operand capture, accumulation and result registration
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_q   <= '0;
      p_q   <= '0;
      acc_q <= '0;
      k_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
    end else if (state_q == IDLE && in_valid) begin
      a_q   <= A;
      p_q   <= P;
      acc_q <= '0;
      k_q   <= '0;
    end else if (state_q == MAC) begin
      acc_q <= acc_d;
      k_q   <= last ? '0 : k_q + KW'(1);
      if (last) begin
        c_q   <= c_d;
        ovf_q <= ovf_d;
      end
    end
  assign C   = c_q;
  assign ovf = ovf_q;
endmodule
